// File: rtl/wb_reg_slave.sv
// Pipelined Wishbone register slave: ID word, free-running cycle counter, and RW scratch registers.
// Optional macro WB_SLAVE_STALL_EN: after every accepted request, stall for one cycle.
module wb_reg_slave #(
  parameter int          NREGS    = 8,
  parameter int          ACK_LAT  = 1,
  parameter logic [31:0] ID_VALUE = 32'h57425331
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_stall,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_data
);
  localparam int AW = $clog2(NREGS);

  logic [31:0]        r_cnt;
  logic [31:0]        r_regs [NREGS];
  logic [ACK_LAT-1:0] r_vld_pipe;
  logic [ACK_LAT-1:0] r_err_pipe;
  logic [31:0]        r_dat_pipe [ACK_LAT];

  logic        w_stall;
  logic        w_acc;
  logic        w_hit;
  logic        w_wr;
  logic [31:0] w_idx32;
  logic [31:0] w_rdata;

  assign w_acc   = i_wb_cyc & i_wb_stb & ~w_stall;
  assign w_idx32 = 32'(i_wb_addr[AW-1:0]);
  assign w_hit   = (i_wb_addr[29:AW] == '0) && (w_idx32 < 32'(NREGS));
  assign w_wr    = w_acc & i_wb_we & w_hit;

`ifdef WB_SLAVE_STALL_EN
  logic r_stall;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_stall <= 1'b0;
    else         r_stall <= w_acc;
  end
  assign w_stall = r_stall;
`else
  assign w_stall = 1'b0;
`endif
  assign o_wb_stall = w_stall;

  always_comb begin
    w_rdata = '0;
    if (w_idx32 == 32'd0)      w_rdata = ID_VALUE;
    else if (w_idx32 == 32'd1) w_rdata = r_cnt;
    else
      for (int k = 2; k < NREGS; k++)
        if (w_idx32 == 32'(k)) w_rdata = r_regs[k];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_cnt <= '0;
    else         r_cnt <= r_cnt + 32'd1;
  end

  // Slots 0 and 1 are never written; ID and counter are read from elsewhere.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else if (w_wr) begin
      for (int k = 2; k < NREGS; k++)
        if (w_idx32 == 32'(k))
          for (int b = 0; b < 4; b++)
            if (i_wb_sel[b]) r_regs[k][8*b +: 8] <= i_wb_data[8*b +: 8];
    end
  end

  // Stage 0 is loaded at the accept edge; the output registers follow the
  // last stage, so the response appears ACK_LAT edges after acceptance.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_vld_pipe <= '0;
      r_err_pipe <= '0;
      for (int s = 0; s < ACK_LAT; s++) r_dat_pipe[s] <= '0;
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
    end else if (!i_wb_cyc) begin
      r_vld_pipe <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_err   <= 1'b0;
      o_wb_data  <= '0;
    end else begin
      r_vld_pipe[0] <= w_acc;
      r_err_pipe[0] <= ~w_hit;
      r_dat_pipe[0] <= (w_acc && w_hit && !i_wb_we) ? w_rdata : '0;
      for (int s = 1; s < ACK_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_err_pipe[s] <= r_err_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
      o_wb_ack  <= r_vld_pipe[ACK_LAT-1] & ~r_err_pipe[ACK_LAT-1];
      o_wb_err  <= r_vld_pipe[ACK_LAT-1] &  r_err_pipe[ACK_LAT-1];
      o_wb_data <= (r_vld_pipe[ACK_LAT-1] && !r_err_pipe[ACK_LAT-1]) ?
                   r_dat_pipe[ACK_LAT-1] : '0;
    end
  end
endmodule

// File: doc/wb_reg_slave.md
Name: wb_reg_slave

Overview:
- Pipelined Wishbone responder: the far end of the bus driven by the UART-bridge Wishbone master.
- Implements a small register file with an ID word, a free-running cycle counter and RW scratch registers.
- Answers every accepted request with exactly one ack or err after a fixed, parameterised latency.
- Serves as the default bring-up/loopback target on the debug bus.

Parameters:
- NREGS, 8: number of 32-bit registers; legal range 4..64.
- ACK_LAT, 1: cycles from request acceptance to ack/err; legal range 1..4.
- ID_VALUE, 32'h57425331: constant returned by register 0.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc  in  1  bus cycle in progress
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1=write, 0=read
- i_wb_addr  in  30  word address
- i_wb_data  in  32  write data
- i_wb_sel  in  4  byte enables; bit n covers data[8n+7:8n]
- o_wb_stall  out  1  request not accepted this cycle
- o_wb_ack  out  1  request completed
- o_wb_err  out  1  request failed (bad address)
- o_wb_data  out  32  read data, valid with o_wb_ack

Behaviour:
- Reset (async assert, sync release): o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_wb_stall=0, all registers=0, counter=0, pipeline valid bits cleared. Reset mid-transaction drops all in-flight responses; no ack/err follows.
- Accept condition: i_wb_cyc & i_wb_stb & !o_wb_stall at a rising edge. One request can be accepted per cycle.
- Decode:
  - idx = i_wb_addr[$clog2(NREGS)-1:0].
  - Request is valid iff all upper address bits are 0 and idx < NREGS; otherwise the response is err.
- Register map:
  - 0 = ID_VALUE, read-only.
  - 1 = cycle counter, read-only.
  - 2..NREGS-1 = read/write.
  - Writes to 0 or 1 are ignored but still acked (no err).
- Writes:
  - Committed at the accept edge, byte-wise per i_wb_sel. sel=0 is acked with no change.
  - A write never returns err if the address decodes as valid.
- Reads: data is captured at the accept edge (pre-write value of the same cycle is irrelevant, since one request per cycle). A read accepted the cycle after a write to the same register returns the new value.
- Counter: 32-bit, increments every cycle after reset, wraps FFFFFFFF->00000000. A read returns the value present at the accept edge.
- Response pipeline:
  - ACK_LAT-deep shift register of {valid, err, data}.
  - A request accepted at edge N gives o_wb_ack or o_wb_err high for exactly one cycle starting at edge N+ACK_LAT.
  - Ack and err are never high together. Back-to-back requests give back-to-back acks in order.
- o_wb_data: equals read data when ack is for a read; 0 otherwise (write acks, err, idle).
- Cycle abort: if i_wb_cyc is low at an edge, all pipeline valid bits clear. No ack/err is issued for aborted requests, including in that same cycle's output. Already committed writes persist.
- i_wb_stb while i_wb_cyc=0 is ignored.

Optional Feature:
- Macro WB_SLAVE_STALL_EN.
- Defined: o_wb_stall is registered and goes high for exactly one cycle after every accepted request (max one accept per 2 cycles). This exercises the master stall path. Stall clears on reset and when i_wb_cyc=0.
- Undefined: o_wb_stall is tied 0.

Test Plan:
- Read addr 0 after reset, ACK_LAT=1 -> ack one cycle after accept, o_wb_data=32'h57425331, err=0.
- Write addr 2 data 32'hDEADBEEF sel=4'b0101, then read addr 2 -> ack on both, read returns 32'h00AD00EF.
- Read addr 30'h100 (NREGS=8) -> o_wb_err pulse at N+ACK_LAT, o_wb_ack=0, o_wb_data=0. Write to addr 1 -> ack, counter unaffected.
- ACK_LAT=3, four back-to-back reads of addr 2..5 -> four consecutive acks starting 3 cycles after first accept, in order. Drop i_wb_cyc after the second ack -> no further acks.
- Two reads of addr 1, 10 cycles apart -> difference 10. Force counter to 32'hFFFFFFFE and read 2 cycles later -> 32'h00000000.
- WB_SLAVE_STALL_EN defined, stb held high for 6 cycles -> stall toggles 0,1,0,1..., 3 requests accepted, 3 acks. Assert i_reset mid-burst -> ack/err/data drop to 0 immediately, no responses after release.
